uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 41 ++++
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, bit-period and parity constants.
// Latency: n/a. Backpressure: n/a.
// Bit-period normalisation helper maps any unsupported prescale to 8.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic [5:0] norm_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit sampler: captures the line mid-bit, or a 2-of-3 vote when UART_RX_MAJORITY_EN is defined.
// Latency: bit_val settles within two clocks of mid-bit, well before the bit ends.
// Backpressure: none.
module uart_rx_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] half,
    output logic       bit_val
);

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] smp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= '0;
        end else begin
            if (edge_cnt == half - 6'd1) smp[0] <= rx_in;
            if (edge_cnt == half)        smp[1] <= rx_in;
            if (edge_cnt == half + 6'd1) smp[2] <= rx_in;
        end
    end

    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
`else
    logic smp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= 1'b0;
        end else if (edge_cnt == half) begin
            smp <= rx_in;
        end
    end

    assign bit_val = smp;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, stop; UART_RX_MAJORITY_EN selects voting.
// Latency: data_valid/par_err/stop_err pulse and P_DATA updates on the edge ending the stop bit.
// Backpressure: none; results are one-clock pulses and must be consumed when they appear.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    rx_state_t             state, next_state;
    logic [5:0]            edge_cnt, pre_q, half;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q, par_typ_q, par_flag;
    logic                  bit_val, bit_end, last_data, start_det;

    assign half      = {1'b0, pre_q[5:1]};
    assign bit_end   = (edge_cnt == pre_q - 6'd1);
    assign last_data = (bit_cnt == CW'(DATA_WIDTH - 1));
    // The detecting clock is edge count 0, so the counter restarts at 1.
    assign start_det = (state == IDLE) && !RX_IN;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (RX_IN),
        .edge_cnt (edge_cnt),
        .half     (half),
        .bit_val  (bit_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Returning to IDLE at the stop-bit end lets a zero-gap start bit be caught on the very next clock.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (bit_end) next_state = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && last_data) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            pre_q      <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_flag   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            if (start_det) begin
                edge_cnt  <= 6'd1;
                bit_cnt   <= '0;
                par_flag  <= 1'b0;
                pre_q     <= norm_prescale(Prescale);
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end else if (state != IDLE) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end
            if (bit_end) begin
                case (state)
                    DATA: begin
                        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY: par_flag <= (bit_val != ((^shift_reg) ^ par_typ_q));
                    STOP: begin
                        data_valid <= !par_flag && bit_val;
                        par_err    <= par_flag;
                        stop_err   <= !bit_val;
                        if (!par_flag && bit_val) P_DATA <= shift_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written multi-frame, glitch and reset sequences.
// Build with or without UART_RX_MAJORITY_EN; the mid-bit glitch expectation follows the macro.
module tb_uart_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    Prescale;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stop_err;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n_dv  = 0;
    int n_pe  = 0;
    int n_se  = 0;
    int dv_t [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            if (n_dv < 64) dv_t[n_dv] = cyc;
            n_dv = n_dv + 1;
        end
        if (par_err)  n_pe = n_pe + 1;
        if (stop_err) n_se = n_se + 1;
    end

    typedef struct {
        logic [5:0] pre;       // value on the Prescale port
        int         bitlen;    // actual line bit length in clocks
        logic       par_en;
        logic       par_typ;
        logic       par_flip;  // send the wrong parity bit
        logic       stop_bit;
        logic       scr;       // scramble config inputs after the start bit
        logic [7:0] data;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_pd;
    } vec_t;

    vec_t vec [8];
    int   b_dv, b_pe, b_se;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic hold(input logic b, input int n);
        RX_IN = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input int p, input logic scr);
        hold(1'b0, p);
        if (scr) begin
            Prescale = 6'd8;
            PAR_EN   = ~PAR_EN;
            PAR_TYP  = ~PAR_TYP;
        end
        for (int i = 0; i < 8; i++) hold(d[i], p);
        if (pe) hold(pb, p);
        hold(sb, p);
    endtask

    task automatic snap();
        b_dv = n_dv;
        b_pe = n_pe;
        b_se = n_se;
    endtask

    task automatic chk_counts(input string tag, input int dv, input int pe, input int se);
        chk({tag, " data_valid pulses"}, n_dv - b_dv, dv);
        chk({tag, " par_err pulses"},    n_pe - b_pe, pe);
        chk({tag, " stop_err pulses"},   n_se - b_se, se);
    endtask

    initial begin
        logic pbit;
        vec_t v;

        //           pre    len par typ flip stop scr data    dv pe se  P_DATA
        vec[0] = '{6'd8,  8,  1, 1, 0, 1, 0, 8'hF0, 1, 0, 0, 8'hF0};
        vec[1] = '{6'd8,  8,  1, 0, 1, 1, 0, 8'hA5, 0, 1, 0, 8'hF0};
        vec[2] = '{6'd16, 16, 0, 0, 0, 0, 0, 8'h3C, 0, 0, 1, 8'hF0};
        vec[3] = '{6'd16, 16, 0, 0, 0, 1, 0, 8'h3C, 1, 0, 0, 8'h3C};
        vec[4] = '{6'd32, 32, 1, 0, 0, 1, 1, 8'h81, 1, 0, 0, 8'h81};
        vec[5] = '{6'd13, 8,  1, 1, 0, 1, 0, 8'h5A, 1, 0, 0, 8'h5A};
        vec[6] = '{6'd16, 16, 1, 0, 1, 0, 0, 8'h77, 0, 1, 1, 8'h5A};
        vec[7] = '{6'd8,  8,  0, 1, 0, 1, 0, 8'hFF, 1, 0, 0, 8'hFF};

        rst      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("reset P_DATA",     int'(P_DATA),     0);
        chk("reset data_valid", int'(data_valid), 0);
        chk("reset par_err",    int'(par_err),    0);
        chk("reset stop_err",   int'(stop_err),   0);
        rst = 1'b1;
        hold(1'b1, 4);

        for (int i = 0; i < 8; i++) begin
            v        = vec[i];
            PAR_EN   = v.par_en;
            PAR_TYP  = v.par_typ;
            Prescale = v.pre;
            pbit     = (^v.data) ^ v.par_typ ^ v.par_flip;
            snap();
            send_frame(v.data, v.par_en, pbit, v.stop_bit, v.bitlen, v.scr);
            PAR_EN   = v.par_en;
            PAR_TYP  = v.par_typ;
            Prescale = v.pre;
            hold(1'b1, 4);
            chk_counts($sformatf("vec%0d", i), v.exp_dv, v.exp_pe, v.exp_se);
            chk($sformatf("vec%0d P_DATA", i), int'(P_DATA), int'(v.exp_pd));
        end

        // Back-to-back 0xF0 then 0x0F, odd parity, zero idle gap: pulses 88 clocks apart.
        PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd8;
        snap();
        send_frame(8'hF0, 1'b1, 1'b1, 1'b1, 8, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 8, 1'b0);
        hold(1'b1, 4);
        chk_counts("b2b", 2, 0, 0);
        if (n_dv - b_dv == 2) chk("b2b pulse spacing", dv_t[b_dv + 1] - dv_t[b_dv], 88);
        chk("b2b P_DATA", int'(P_DATA), 8'h0F);

        // Three-clock low glitch: start bit rejected, then a normal frame.
        snap();
        hold(1'b0, 3);
        hold(1'b1, 10);
        chk_counts("glitch", 0, 0, 0);
        chk("glitch P_DATA held", int'(P_DATA), 8'h0F);
        snap();
        send_frame(8'h96, 1'b1, 1'b1, 1'b1, 8, 1'b0);
        hold(1'b1, 4);
        chk_counts("post-glitch", 1, 0, 0);
        chk("post-glitch P_DATA", int'(P_DATA), 8'h96);

        // Reset during data bit 4 of 0xC3, no parity.
        PAR_EN = 1'b0;
        snap();
        hold(1'b0, 8);
        for (int i = 0; i < 4; i++) hold(((8'hC3 >> i) & 8'h01) != 0, 8);
        hold(1'b0, 4);
        rst = 1'b0;
        hold(1'b0, 2);
        chk("midreset P_DATA cleared", int'(P_DATA), 0);
        chk("midreset data_valid",     int'(data_valid), 0);
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 5);
        chk_counts("midreset", 0, 0, 0);
        snap();
        send_frame(8'h6B, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        hold(1'b1, 4);
        chk_counts("after-reset", 1, 0, 0);
        chk("after-reset P_DATA", int'(P_DATA), 8'h6B);

        // One-clock inverted glitch at edge count 4 of data bit 2 (0x55, even parity bit 0).
        PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8;
        snap();
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 4);
        hold(1'b0, 1);
        hold(1'b1, 3);
        for (int i = 3; i < 8; i++) hold(((8'h55 >> i) & 8'h01) != 0, 8);
        hold(1'b0, 8);
        hold(1'b1, 8);
        hold(1'b1, 4);
`ifdef UART_RX_MAJORITY_EN
        chk_counts("vote", 1, 0, 0);
        chk("vote P_DATA", int'(P_DATA), 8'h55);
`else
        chk_counts("vote", 0, 1, 0);
        chk("vote P_DATA", int'(P_DATA), 8'h6B);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
